pipe_scoreboard: RTL and testbench

Parametrised register scoreboard and hazard unit for the next-generation execute pipeline, which has variable-latency integer/float units. It tracks pending writes to the integer and floating register files, and stalls decode on RAW and WAW hazards. It also drives same-cycle writeback bypass selects. It sits between decode and the issue/execute stage and replaces the fixed-distance forwarding/stall logic.

---
 rtl/pipe_scoreboard_if.sv | 41 ++++
 rtl/pipe_scoreboard.sv | 132 +++++++++++++
 tb/tb_pipe_scoreboard.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_if.sv
// Decode/writeback signal bundle for pipe_scoreboard: decode drives through master,
// the scoreboard consumes it through slave.
interface pipe_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned CNT_W      = 6
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rs1;
  logic                  rs1_file;
  logic                  rs1_use;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs2_file;
  logic                  rs2_use;
  logic [REG_ADDR_W-1:0] rd;
  logic                  rd_file;
  logic                  rd_we;
  logic [LAT_W-1:0]      rd_lat;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_file;
  logic                  fwd_a;
  logic                  fwd_b;
  logic                  stall;
  logic [CNT_W-1:0]      pending_count;
  logic                  drained;

  modport master (
    output issue_valid, flush, rs1, rs1_file, rs1_use, rs2, rs2_file, rs2_use,
           rd, rd_file, rd_we, rd_lat, wb_valid, wb_rd, wb_file,
    input  issue_ready, fwd_a, fwd_b, stall, pending_count, drained
  );

  modport slave (
    input  issue_valid, flush, rs1, rs1_file, rs1_use, rs2, rs2_file, rs2_use,
           rd, rd_file, rd_we, rd_lat, wb_valid, wb_rd, wb_file,
    output issue_ready, fwd_a, fwd_b, stall, pending_count, drained
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Register scoreboard / hazard unit for the variable-latency execute pipeline.
// Define SCOREBOARD_STATS_EN to add saturating stall statistics outputs.
module pipe_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MAX_LAT    = 4,
  parameter int unsigned LAT_W      = 3,
  parameter int unsigned CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  pipe_scoreboard_if.slave  sb
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [15:0]       stat_raw_stalls,
  output logic [15:0]       stat_waw_stalls
`endif
);

  logic [NUM_REGS-1:0] busy_q [2];
  logic [NUM_REGS-1:0] busy_d [2];
  logic [LAT_W-1:0]    rem_q  [2][NUM_REGS];
  logic [LAT_W-1:0]    rem_d  [2][NUM_REGS];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                drained_q;

  logic             wb_hit_a, wb_hit_b, wb_hit_w;
  logic             busy_a, busy_b, busy_w;
  logic             raw_a, raw_b, waw, fire, stall;
  logic [LAT_W-1:0] eff_lat;

  // Int x0 is never set busy, so no extra masking is needed on the lookups.
  assign busy_a   = busy_q[sb.rs1_file][sb.rs1];
  assign busy_b   = busy_q[sb.rs2_file][sb.rs2];
  assign busy_w   = busy_q[sb.rd_file][sb.rd];
  assign wb_hit_a = sb.wb_valid & (sb.wb_file == sb.rs1_file) & (sb.wb_rd == sb.rs1);
  assign wb_hit_b = sb.wb_valid & (sb.wb_file == sb.rs2_file) & (sb.wb_rd == sb.rs2);
  assign wb_hit_w = sb.wb_valid & (sb.wb_file == sb.rd_file) & (sb.wb_rd == sb.rd);

  always_comb begin
    if (sb.rd_lat == '0) begin
      eff_lat = LAT_W'(1);
    end else if (sb.rd_lat > LAT_W'(MAX_LAT)) begin
      eff_lat = LAT_W'(MAX_LAT);
    end else begin
      eff_lat = sb.rd_lat;
    end
  end

  assign raw_a = sb.rs1_use & busy_a & ~wb_hit_a;
  assign raw_b = sb.rs2_use & busy_b & ~wb_hit_b;
  // Block a younger write that could land before an older in-flight one.
  assign waw   = sb.rd_we & busy_w & ~wb_hit_w & (rem_q[sb.rd_file][sb.rd] >= eff_lat);

  assign sb.issue_ready   = ~raw_a & ~raw_b & ~waw;
  assign sb.fwd_a         = sb.rs1_use & busy_a & wb_hit_a;
  assign sb.fwd_b         = sb.rs2_use & busy_b & wb_hit_b;
  assign stall            = sb.issue_valid & ~sb.issue_ready;
  assign sb.stall         = stall;
  assign fire             = sb.issue_valid & sb.issue_ready & ~sb.flush;
  assign sb.pending_count = count_q;
  assign sb.drained       = drained_q;

  always_comb begin
    busy_d  = busy_q;
    rem_d   = rem_q;
    count_d = '0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (busy_q[f][r] && rem_q[f][r] != '0) begin
          rem_d[f][r] = rem_q[f][r] - LAT_W'(1);
        end
        if (busy_q[f][r] && sb.wb_valid && sb.wb_file == f[0] &&
            sb.wb_rd == r[REG_ADDR_W-1:0]) begin
          busy_d[f][r] = 1'b0;
          rem_d[f][r]  = '0;
        end
        // A new issue to the same entry overrides a coincident writeback.
        if (fire && sb.rd_we && sb.rd_file == f[0] && sb.rd == r[REG_ADDR_W-1:0] &&
            !(f == 0 && r == 0)) begin
          busy_d[f][r] = 1'b1;
          rem_d[f][r]  = eff_lat;
        end
        count_d = count_d + CNT_W'(busy_d[f][r]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < 2; f++) begin
        busy_q[f] <= '0;
        for (int r = 0; r < NUM_REGS; r++) begin
          rem_q[f][r] <= '0;
        end
      end
      count_q   <= '0;
      drained_q <= 1'b1;
    end else begin
      busy_q    <= busy_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      drained_q <= (count_d == '0);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] raw_cnt_q, waw_cnt_q;
  logic        raw_any;

  assign raw_any = raw_a | raw_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      raw_cnt_q   <= '0;
      waw_cnt_q   <= '0;
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (raw_any && raw_cnt_q != '1) raw_cnt_q <= raw_cnt_q + 16'd1;
      if (!raw_any && waw && waw_cnt_q != '1) waw_cnt_q <= waw_cnt_q + 16'd1;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_raw_stalls   = raw_cnt_q;
  assign stat_waw_stalls   = waw_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed self-checking bench for pipe_scoreboard.
module tb_pipe_scoreboard;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_scoreboard_if sb_if ();

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [15:0] stat_raw_stalls;
  logic [15:0] stat_waw_stalls;
`endif

  pipe_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_raw_stalls   (stat_raw_stalls),
    .stat_waw_stalls   (stat_waw_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    sb_if.issue_valid = 1'b0;
    sb_if.flush       = 1'b0;
    sb_if.rs1         = '0;
    sb_if.rs1_file    = 1'b0;
    sb_if.rs1_use     = 1'b0;
    sb_if.rs2         = '0;
    sb_if.rs2_file    = 1'b0;
    sb_if.rs2_use     = 1'b0;
    sb_if.rd          = '0;
    sb_if.rd_file     = 1'b0;
    sb_if.rd_we       = 1'b0;
    sb_if.rd_lat      = '0;
    sb_if.wb_valid    = 1'b0;
    sb_if.wb_rd       = '0;
    sb_if.wb_file     = 1'b0;
  endtask

  task automatic present_issue(input logic [4:0] r, input logic f, input logic [2:0] lat);
    sb_if.issue_valid = 1'b1;
    sb_if.rd          = r;
    sb_if.rd_file     = f;
    sb_if.rd_we       = 1'b1;
    sb_if.rd_lat      = lat;
  endtask

  task automatic present_wb(input logic [4:0] r, input logic f);
    sb_if.wb_valid = 1'b1;
    sb_if.wb_rd    = r;
    sb_if.wb_file  = f;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.fwd_a !== 1'b0) begin errors++; $display("FAIL reset_fwd_a: got %b want 0", sb_if.fwd_a); end
    checks++; if (sb_if.fwd_b !== 1'b0) begin errors++; $display("FAIL reset_fwd_b: got %b want 0", sb_if.fwd_b); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", sb_if.stall); end
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL reset_pending: got %0d want 0", sb_if.pending_count); end
    checks++; if (sb_if.drained !== 1'b1) begin errors++; $display("FAIL reset_drained: got %b want 1", sb_if.drained); end
  endtask

  task automatic test_raw();
    @(negedge clk); clear_inputs(); present_issue(5'd5, 1'b0, 3'd3); #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs();
    sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd5; sb_if.rs1_use = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL raw_ready: got %b want 0", sb_if.issue_ready); end
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", sb_if.stall); end
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL raw_pending: got %0d want 1", sb_if.pending_count); end
    checks++; if (sb_if.drained !== 1'b0) begin errors++; $display("FAIL raw_drained: got %b want 0", sb_if.drained); end
    @(negedge clk); present_wb(5'd5, 1'b0); #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.fwd_a !== 1'b1) begin errors++; $display("FAIL raw_fwd_a: got %b want 1", sb_if.fwd_a); end
    checks++; if (sb_if.fwd_b !== 1'b0) begin errors++; $display("FAIL raw_fwd_b: got %b want 0", sb_if.fwd_b); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL raw_wb_stall: got %b want 0", sb_if.stall); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL raw_after_pending: got %0d want 0", sb_if.pending_count); end
    checks++; if (sb_if.drained !== 1'b1) begin errors++; $display("FAIL raw_after_drained: got %b want 1", sb_if.drained); end
  endtask

  task automatic test_reg_zero();
    @(negedge clk); clear_inputs(); present_issue(5'd0, 1'b0, 3'd2);
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL x0_pending: got %0d want 0", sb_if.pending_count); end
    sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd0; sb_if.rs1_use = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL x0_read_ready: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs(); present_issue(5'd0, 1'b1, 3'd2);
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL f0_pending: got %0d want 1", sb_if.pending_count); end
    sb_if.issue_valid = 1'b1;
    sb_if.rs1 = 5'd0; sb_if.rs1_file = 1'b1; sb_if.rs1_use = 1'b1;
    sb_if.rs2 = 5'd0; sb_if.rs2_file = 1'b1; sb_if.rs2_use = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL f0_read_ready: got %b want 0", sb_if.issue_ready); end
    @(negedge clk); #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL f0_hold_ready: got %b want 0", sb_if.issue_ready); end
    @(negedge clk); present_wb(5'd0, 1'b1); #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL f0_wb_ready: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.fwd_a !== 1'b1) begin errors++; $display("FAIL f0_fwd_a: got %b want 1", sb_if.fwd_a); end
    checks++; if (sb_if.fwd_b !== 1'b1) begin errors++; $display("FAIL f0_fwd_b: got %b want 1", sb_if.fwd_b); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL f0_after_pending: got %0d want 0", sb_if.pending_count); end
  endtask

  task automatic test_waw();
    @(negedge clk); clear_inputs(); present_issue(5'd7, 1'b1, 3'd4);
    @(negedge clk); clear_inputs(); present_issue(5'd7, 1'b1, 3'd1); #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_ready: got %b want 0", sb_if.issue_ready); end
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", sb_if.stall); end
    @(negedge clk); #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_hold_ready: got %b want 0", sb_if.issue_ready); end
    @(negedge clk); present_wb(5'd7, 1'b1); #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_ready: got %b want 1", sb_if.issue_ready); end
    // Entry now holds rem = 1: probe it through the WAW threshold without issuing.
    @(negedge clk); clear_inputs();
    sb_if.rd = 5'd7; sb_if.rd_file = 1'b1; sb_if.rd_we = 1'b1; sb_if.rd_lat = 3'd2; #1;
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL waw_pending: got %0d want 1", sb_if.pending_count); end
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL waw_rem1_lat2: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL waw_novalid_stall: got %b want 0", sb_if.stall); end
    sb_if.rd_lat = 3'd1; #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_rem1_lat1: got %b want 0", sb_if.issue_ready); end
    sb_if.rd_lat = 3'd0; #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_rem1_lat0: got %b want 0", sb_if.issue_ready); end
    sb_if.rd_lat = 3'd7; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL waw_rem1_lat7: got %b want 1", sb_if.issue_ready); end
    // rem saturates at 0 but the entry stays busy.
    @(negedge clk); sb_if.rd_lat = 3'd1; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL waw_rem0_lat1: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs(); sb_if.rs1 = 5'd7; sb_if.rs1_file = 1'b1; sb_if.rs1_use = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL waw_rem0_raw: got %b want 0", sb_if.issue_ready); end
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL waw_rem0_pending: got %0d want 1", sb_if.pending_count); end
    @(negedge clk); clear_inputs(); present_wb(5'd7, 1'b1);
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL waw_after_pending: got %0d want 0", sb_if.pending_count); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk); clear_inputs(); present_issue(5'd9, 1'b0, 3'd3);
    @(negedge clk); clear_inputs(); present_issue(5'd9, 1'b0, 3'd2); present_wb(5'd9, 1'b0); #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL same_pending_before: got %0d want 1", sb_if.pending_count); end
    @(negedge clk); clear_inputs();
    sb_if.rd = 5'd9; sb_if.rd_we = 1'b1; sb_if.rd_lat = 3'd2; #1;
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL same_pending_after: got %0d want 1", sb_if.pending_count); end
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL same_rem2_lat2: got %b want 0", sb_if.issue_ready); end
    sb_if.rd_lat = 3'd3; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL same_rem2_lat3: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs(); present_wb(5'd9, 1'b0);
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL same_drain: got %0d want 0", sb_if.pending_count); end
  endtask

  task automatic test_flush();
    @(negedge clk); clear_inputs(); present_issue(5'd12, 1'b0, 3'd2); sb_if.flush = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL flush_no_set: got %0d want 0", sb_if.pending_count); end
    sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd12; sb_if.rs1_use = 1'b1; #1;
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL flush_read_ready: got %b want 1", sb_if.issue_ready); end
    @(negedge clk); clear_inputs(); present_issue(5'd13, 1'b0, 3'd3);
    @(negedge clk); clear_inputs(); sb_if.flush = 1'b1; present_wb(5'd13, 1'b0); #1;
    checks++; if (sb_if.pending_count !== 6'd1) begin errors++; $display("FAIL flush_wb_before: got %0d want 1", sb_if.pending_count); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL flush_wb_accept: got %0d want 0", sb_if.pending_count); end
    checks++; if (sb_if.drained !== 1'b1) begin errors++; $display("FAIL flush_drained: got %b want 1", sb_if.drained); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); clear_inputs(); present_issue(5'd3, 1'b0, 3'd4);
    @(negedge clk); clear_inputs(); present_issue(5'd4, 1'b1, 3'd4);
    @(negedge clk); clear_inputs();
    sb_if.issue_valid = 1'b1;
    sb_if.rs1 = 5'd3; sb_if.rs1_use = 1'b1;
    sb_if.rs2 = 5'd4; sb_if.rs2_file = 1'b1; sb_if.rs2_use = 1'b1; #1;
    checks++; if (sb_if.pending_count !== 6'd2) begin errors++; $display("FAIL mrst_pending_before: got %0d want 2", sb_if.pending_count); end
    checks++; if (sb_if.issue_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready_before: got %b want 0", sb_if.issue_ready); end
    rst = 1'b0; #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL mrst_pending: got %0d want 0", sb_if.pending_count); end
    checks++; if (sb_if.drained !== 1'b1) begin errors++; $display("FAIL mrst_drained: got %b want 1", sb_if.drained); end
    checks++; if (sb_if.issue_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", sb_if.issue_ready); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL mrst_stall: got %b want 0", sb_if.stall); end
    @(negedge clk); rst = 1'b1; clear_inputs(); present_wb(5'd3, 1'b0);
    @(negedge clk); clear_inputs(); #1;
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL mrst_stale_wb: got %0d want 0", sb_if.pending_count); end
  endtask

`ifdef SCOREBOARD_STATS_EN
  task automatic test_stats();
    @(negedge clk); clear_inputs(); rst = 1'b0; #1;
    checks++; if (stat_stall_cycles !== 32'd0) begin errors++; $display("FAIL stats_init_stall: got %0d want 0", stat_stall_cycles); end
    rst = 1'b1;
    @(negedge clk); clear_inputs(); present_issue(5'd5, 1'b0, 3'd4);
    repeat (3) begin
      @(negedge clk); clear_inputs();
      sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd5; sb_if.rs1_use = 1'b1;
    end
    @(negedge clk); clear_inputs(); present_issue(5'd6, 1'b0, 3'd4);
    repeat (2) begin
      @(negedge clk); clear_inputs(); present_issue(5'd6, 1'b0, 3'd1);
    end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (stat_stall_cycles !== 32'd5) begin errors++; $display("FAIL stats_stall: got %0d want 5", stat_stall_cycles); end
    checks++; if (stat_raw_stalls !== 16'd3) begin errors++; $display("FAIL stats_raw: got %0d want 3", stat_raw_stalls); end
    checks++; if (stat_waw_stalls !== 16'd2) begin errors++; $display("FAIL stats_waw: got %0d want 2", stat_waw_stalls); end
    sb_if.issue_valid = 1'b1; sb_if.rs1 = 5'd6; sb_if.rs1_use = 1'b1; #1;
    checks++; if (sb_if.stall !== 1'b1) begin errors++; $display("FAIL stats_prestall: got %b want 1", sb_if.stall); end
    rst = 1'b0; #1;
    checks++; if (stat_stall_cycles !== 32'd0) begin errors++; $display("FAIL stats_rst_stall: got %0d want 0", stat_stall_cycles); end
    checks++; if (stat_raw_stalls !== 16'd0) begin errors++; $display("FAIL stats_rst_raw: got %0d want 0", stat_raw_stalls); end
    checks++; if (stat_waw_stalls !== 16'd0) begin errors++; $display("FAIL stats_rst_waw: got %0d want 0", stat_waw_stalls); end
    checks++; if (sb_if.pending_count !== 6'd0) begin errors++; $display("FAIL stats_rst_pending: got %0d want 0", sb_if.pending_count); end
    checks++; if (sb_if.stall !== 1'b0) begin errors++; $display("FAIL stats_rst_busy: got %b want 0", sb_if.stall); end
    @(negedge clk); rst = 1'b1; clear_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    clk    = 1'b0;
    rst    = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_raw();
    test_reg_zero();
    test_waw();
    test_same_cycle();
    test_flush();
    test_mid_reset();
`ifdef SCOREBOARD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
